imem_responder: RTL

- Instruction-memory responder: the memory side of the instruction-fetch interface.
- Accepts word-fetch requests through a valid/ready request channel.
- Returns instruction words through a valid/ready response channel after a fixed, configurable latency.
- Supports multiple outstanding fetches, a flush for branch/jump redirect, and a preload write port used by benches and boot logic.

---
 rtl/imem_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: word fetches answered in order after LATENCY cycles.
// Outstanding fetches are bounded so the response FIFO can never overflow; flush drops everything in flight.
module imem_responder #(
   parameter int DEPTH_WORDS     = 1024,
   parameter int LATENCY         = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [31:0]                    req_addr,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [31:0]                    rsp_data,
   output logic                           rsp_err,
   input  logic                           flush,
   input  logic                           ld_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [31:0]                    ld_data
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic        vld;
      logic        err;
      logic [31:0] dat;
   } ent_t;

   logic [31:0]                mem_q [DEPTH_WORDS];
   logic [31:0]                fifo_dat_q [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] fifo_err_q;
   logic [PW-1:0]              rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]              fcnt_q, fcnt_d;
   logic [CW-1:0]              outst_q, outst_d;
   logic [31:0]                last_dat_q;
   logic                       last_err_q;
   logic                       accept, pop, fifo_wr, fifo_empty, addr_err;
   logic [31:0]                head_dat;
   logic                       head_err;
   ent_t                       in_ent, tail_ent;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // Gating with rst_n keeps the request side closed while reset is held.
   assign req_ready = rst_n && (outst_q < CW'(MAX_OUTSTANDING)) && !flush;
   assign accept    = req_valid && req_ready;

   assign fifo_empty = (fcnt_q == '0);
   assign rsp_valid  = !fifo_empty && !flush;
   assign pop        = rsp_valid && rsp_ready;
   assign fifo_wr    = tail_ent.vld && !flush;

   assign head_dat = fifo_dat_q[rd_ptr_q];
   assign head_err = fifo_err_q[rd_ptr_q];
   assign rsp_data = fifo_empty ? last_dat_q : head_dat;
   assign rsp_err  = fifo_empty ? last_err_q : head_err;

   assign addr_err = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

   always_comb begin
      in_ent     = '0;
      in_ent.vld = accept;
      in_ent.err = addr_err;
      in_ent.dat = addr_err ? NOP : mem_q[req_addr[AW+1:2]];
   end

   // Read-before-write: a fetch in the same cycle as a preload sees the old word.
   always_ff @(posedge clk) begin
      if (ld_we) mem_q[ld_addr] <= ld_data;
   end

   generate
      if (LATENCY == 1) begin : g_nopipe
         assign tail_ent = in_ent;
      end else begin : g_pipe
         ent_t pipe_q [LATENCY-1];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
            end else if (flush) begin
               for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= in_ent;
               for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end
         assign tail_ent = pipe_q[LATENCY-2];
      end
   endgenerate

   always_comb begin
      outst_d = outst_q;
      fcnt_d  = fcnt_q;
      if (flush) begin
         outst_d = '0;
         fcnt_d  = '0;
      end else begin
         if (accept && !pop)      outst_d = outst_q + 1'b1;
         else if (!accept && pop) outst_d = outst_q - 1'b1;
         if (fifo_wr && !pop)      fcnt_d = fcnt_q + 1'b1;
         else if (!fifo_wr && pop) fcnt_d = fcnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_dat_q[wr_ptr_q] <= tail_ent.dat;
         fifo_err_q[wr_ptr_q] <= tail_ent.err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outst_q    <= '0;
         fcnt_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         last_dat_q <= '0;
         last_err_q <= 1'b0;
      end else begin
         outst_q <= outst_d;
         fcnt_q  <= fcnt_d;
         if (!fifo_empty) begin
            last_dat_q <= head_dat;
            last_err_q <= head_err;
         end
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
      end
   end

endmodule
